// File: rtl/bram_burst_reader_pkg.sv
// rtl/bram_burst_reader_pkg.sv - shared state encoding and buffer depth for the burst reader
package bram_burst_reader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_e;

    // Two entries cover the one-cycle RAM read latency at full throughput.
    localparam int FIFO_DEPTH = 2;

endpackage

// File: rtl/bram_rd_fifo.sv
// rtl/bram_rd_fifo.sv - small synchronous first-word-fall-through FIFO for read data and last flag
module bram_rd_fifo
    import bram_burst_reader_pkg::*;
#(
    parameter int  WIDTH = 33,
    parameter int  DEPTH = FIFO_DEPTH,
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic [CW-1:0]    count_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] ptr);
        return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);
    endfunction

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    // A pop of an empty FIFO is dropped; a push into a full FIFO only lands when a pop frees the slot.
    always_comb begin
        do_pop   = pop_i && !empty_o;
        do_push  = push_i && (!full_o || do_pop);
        wr_ptr_d = do_push ? ptr_next(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = do_pop ? ptr_next(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q + CW'(do_push) - CW'(do_pop);
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are only observed through count, so it needs no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/bram_burst_reader.sv
// rtl/bram_burst_reader.sv - credit-limited burst reader from single-port RAM to a valid/ready stream
module bram_burst_reader
    import bram_burst_reader_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADD_WIDTH  = 10,
    parameter int LEN_WIDTH  = ADD_WIDTH + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADD_WIDTH-1:0]  base_add,
    input  logic [LEN_WIDTH-1:0]  length,
    output logic                  busy,
    output logic                  done,
    output logic                  ram_cs,
    output logic                  ram_we,
    output logic                  ram_oe,
    output logic [ADD_WIDTH-1:0]  ram_add,
    input  logic [DATA_WIDTH-1:0] ram_rdata,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int UW = CW + 1;

    state_e               state_q, state_d;
    logic [ADD_WIDTH-1:0] addr_q, addr_d;
    logic [LEN_WIDTH-1:0] rem_q, rem_d;
    logic                 inflight_q, inflight_d;
    logic                 inflight_last_q, inflight_last_d;
    logic                 zero_done_q, zero_done_d;

    logic                  issue;
    logic                  burst_done;
    logic                  pop;
    logic                  fifo_push;
    logic [UW-1:0]         credit_use;
    logic [DATA_WIDTH:0]   fifo_head;
    logic [CW-1:0]         fifo_count;
    logic                  fifo_full;
    logic                  fifo_empty;

    assign out_valid  = !fifo_empty;
    assign pop        = out_valid && out_ready;
    assign out_data   = fifo_empty ? '0 : fifo_head[DATA_WIDTH-1:0];
    assign out_last   = !fifo_empty && fifo_head[DATA_WIDTH];
    assign fifo_push  = inflight_q && (!fifo_full || pop);
    // Slots already claimed (stored plus arriving) after this cycle's pop.
    assign credit_use = UW'(fifo_count) + UW'(inflight_q) - UW'(pop);

    assign ram_cs  = issue;
    assign ram_oe  = issue;
    assign ram_we  = 1'b0;
    assign ram_add = addr_q;
    // A zero-length request counts as busy for its single done cycle.
    assign busy    = (state_q != IDLE) || zero_done_q;
    assign done    = burst_done || zero_done_q;

    // Next-state logic: request acceptance, credit-gated issue, and drain completion.
    always_comb begin
        state_d         = state_q;
        addr_d          = addr_q;
        rem_d           = rem_q;
        inflight_d      = 1'b0;
        inflight_last_d = inflight_last_q;
        zero_done_d     = 1'b0;
        issue           = 1'b0;
        burst_done      = 1'b0;
        case (state_q)
            IDLE: begin
                // The pending zero-length done cycle blocks a new request like a burst's done cycle.
                if (start && !zero_done_q) begin
                    if (length != '0) begin
                        addr_d  = base_add;
                        rem_d   = length;
                        state_d = READ;
                    end else begin
                        zero_done_d = 1'b1;
                    end
                end
            end
            READ: begin
                if (credit_use < UW'(FIFO_DEPTH)) begin
                    issue           = 1'b1;
                    addr_d          = addr_q + ADD_WIDTH'(1);
                    rem_d           = rem_q - LEN_WIDTH'(1);
                    inflight_d      = 1'b1;
                    inflight_last_d = (rem_q == LEN_WIDTH'(1));
                    if (rem_q == LEN_WIDTH'(1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (!inflight_q && fifo_empty) begin
                    burst_done = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, address, remaining count and in-flight tracking registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            addr_q          <= '0;
            rem_q           <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            zero_done_q     <= 1'b0;
        end else begin
            state_q         <= state_d;
            addr_q          <= addr_d;
            rem_q           <= rem_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
            zero_done_q     <= zero_done_d;
        end
    end

    bram_rd_fifo #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (fifo_push),
        .push_data_i ({inflight_last_q, ram_rdata}),
        .pop_i       (pop),
        .head_o      (fifo_head),
        .count_o     (fifo_count),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

endmodule

// File: tb/tb_bram_burst_reader.sv
// tb/tb_bram_burst_reader.sv - table-driven self-checking bench for bram_burst_reader
module tb_bram_burst_reader;

    logic        clk;
    logic        rst;
    logic        start;
    logic [9:0]  base_add;
    logic [10:0] length;
    logic        busy;
    logic        done;
    logic        ram_cs;
    logic        ram_we;
    logic        ram_oe;
    logic [9:0]  ram_add;
    logic [31:0] ram_rdata;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;

    int total;
    int bad;

    logic [31:0] mem [0:1023];

    bram_burst_reader #(
        .DATA_WIDTH (32),
        .ADD_WIDTH  (10),
        .LEN_WIDTH  (11)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_add  (base_add),
        .length    (length),
        .busy      (busy),
        .done      (done),
        .ram_cs    (ram_cs),
        .ram_we    (ram_we),
        .ram_oe    (ram_oe),
        .ram_add   (ram_add),
        .ram_rdata (ram_rdata),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM responder with registered read data
    always @(posedge clk) begin
        if (ram_cs && ram_oe && !ram_we) begin
            ram_rdata <= mem[ram_add];
        end
    end

    typedef struct {
        int         base;
        int         len;
        logic [7:0] rdy_pat;
        int         exp_done;
        int         dup_start;
        int         rst_after;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " busy"}, 64'(busy), 0);
        chk({tag, " done"}, 64'(done), 0);
        chk({tag, " ram_cs"}, 64'(ram_cs), 0);
        chk({tag, " ram_we"}, 64'(ram_we), 0);
        chk({tag, " ram_oe"}, 64'(ram_oe), 0);
        chk({tag, " ram_add"}, 64'(ram_add), 0);
        chk({tag, " out_valid"}, 64'(out_valid), 0);
        chk({tag, " out_last"}, 64'(out_last), 0);
        chk({tag, " out_data"}, 64'(out_data), 0);
    endtask

    task automatic run_vec(input vec_t v, input int vi);
        int          issued;
        int          acc;
        int          m_cnt;
        int          m_inf;
        bit          m_pop;
        bit          exp_issue;
        bit          exp_done;
        bit          done_seen;
        bit          stalled;
        bit          rst_next;
        logic [31:0] held;
        string       tag;
        int          c;
        issued    = 0;
        acc       = 0;
        m_cnt     = 0;
        m_inf     = 0;
        done_seen = 0;
        stalled   = 0;
        rst_next  = 0;
        held      = '0;
        tag       = $sformatf("v%0d", vi);
        for (c = 0; c < 3000 && !done_seen; c++) begin
            if (rst_next) begin
                start     = 1'b0;
                rst       = 1'b1;
                next_cycle();
                rst       = 1'b0;
                out_ready = 1'b1;
                #4;
                chk_reset_vals({tag, " post-reset"});
                for (int k = 0; k < 4; k++) begin
                    next_cycle();
                    #4;
                    chk({tag, " post-reset done"}, 64'(done), 0);
                    chk({tag, " post-reset valid"}, 64'(out_valid), 0);
                    chk({tag, " post-reset cs"}, 64'(ram_cs), 0);
                end
                next_cycle();
                return;
            end
            start     = (c == 0) || (c == v.dup_start);
            base_add  = (c == 0) ? 10'(v.base) : 10'(v.base + 333);
            length    = (c == 0) ? 11'(v.len) : 11'd5;
            out_ready = v.rdy_pat[c[2:0]];
            #4;
            m_pop     = (m_cnt > 0) && out_ready;
            exp_issue = (c >= 1) && (issued < v.len) && (m_cnt + m_inf - int'(m_pop) < 2);
            exp_done  = (c >= 1) && (issued == v.len) && (m_cnt == 0) && (m_inf == 0);
            chk({tag, " out_valid"}, 64'(out_valid), 64'(m_cnt > 0));
            chk({tag, " ram_cs"}, 64'(ram_cs), 64'(exp_issue));
            chk({tag, " ram_oe"}, 64'(ram_oe), 64'(exp_issue));
            chk({tag, " ram_we"}, 64'(ram_we), 0);
            if (exp_issue) begin
                chk({tag, " ram_add"}, 64'(ram_add), 64'((v.base + issued) % 1024));
            end
            if (m_pop) begin
                chk({tag, " out_data"}, 64'(out_data), 64'(((v.base + acc) % 1024) + 100));
                chk({tag, " out_last"}, 64'(out_last), 64'(acc == v.len - 1));
                acc++;
            end
            if (stalled) begin
                chk({tag, " stall hold"}, 64'(out_data), 64'(held));
            end
            stalled = out_valid && !out_ready;
            held    = out_data;
            chk({tag, " done"}, 64'(done), 64'(exp_done));
            chk({tag, " busy"}, 64'(busy), 64'(c >= 1));
            if (exp_done) begin
                done_seen = 1;
                chk({tag, " words at done"}, 64'(acc), 64'(v.len));
                if (v.exp_done >= 0) begin
                    chk({tag, " done cycle"}, 64'(c), 64'(v.exp_done));
                end
            end
            m_cnt  = m_cnt + m_inf - int'(m_pop);
            m_inf  = int'(exp_issue);
            issued = issued + int'(exp_issue);
            chk({tag, " outstanding"}, 64'(m_cnt + m_inf <= 2), 1);
            if (v.rst_after > 0 && acc == v.rst_after) begin
                rst_next = 1;
            end
            next_cycle();
        end
        if (!done_seen) begin
            chk({tag, " timeout"}, 0, 1);
        end
        start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            #4;
            chk({tag, " idle busy"}, 64'(busy), 0);
            chk({tag, " idle cs"}, 64'(ram_cs), 0);
            chk({tag, " idle done"}, 64'(done), 0);
            next_cycle();
        end
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst       = 1'b1;
        start     = 1'b0;
        base_add  = '0;
        length    = '0;
        out_ready = 1'b1;
        ram_rdata = '0;
        for (int i = 0; i < 1024; i++) begin
            mem[i] = 32'(i + 100);
        end

        //          base  len   ready   done  dup   rst
        vecs[0] = '{4,    8,    8'hFF,  11,   -1,   0};
        vecs[1] = '{1022, 4,    8'hFF,  7,    -1,   0};
        vecs[2] = '{10,   6,    8'h49,  -1,   -1,   0};
        vecs[3] = '{50,   5,    8'hFF,  8,    2,    0};
        vecs[4] = '{300,  3,    8'h80,  -1,   -1,   0};
        vecs[5] = '{7,    1,    8'hFF,  4,    4,    0};
        vecs[6] = '{20,   8,    8'h5B,  -1,   -1,   3};
        vecs[7] = '{0,    1024, 8'hFF,  1027, -1,   0};

        next_cycle();
        next_cycle();
        #4;
        chk_reset_vals("reset");
        rst = 1'b0;
        next_cycle();

        // zero-length request, plus a start during its done cycle
        start    = 1'b1;
        base_add = 10'd5;
        length   = 11'd0;
        #4;
        chk("zl c0 busy", 64'(busy), 0);
        next_cycle();
        base_add = 10'd9;
        length   = 11'd2;
        #4;
        chk("zl done", 64'(done), 1);
        chk("zl busy", 64'(busy), 1);
        chk("zl cs", 64'(ram_cs), 0);
        next_cycle();
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #4;
            chk("zl after done", 64'(done), 0);
            chk("zl after busy", 64'(busy), 0);
            chk("zl after cs", 64'(ram_cs), 0);
            next_cycle();
        end

        for (int i = 0; i < 8; i++) begin
            run_vec(vecs[i], i);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
